// File: rtl/pwm_pkg.sv
// Shared state encoding and elaboration-time helpers for the N-channel deadtime PWM.
package pwm_pkg;

   typedef enum logic [2:0] {
      StOff = 3'd0,
      StHi  = 3'd1,
      StLo  = 3'd2,
      StDhi = 3'd3,
      StDlo = 3'd4
   } ch_state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) res = i + 1;
      end
      return (res == 0) ? 1 : res;
   endfunction

   // Carrier offset of channel k; always strictly below the period.
   function automatic int unsigned phase_offset(input int unsigned k,
                                                input int unsigned n,
                                                input int unsigned period,
                                                input int unsigned interleave);
      return (interleave != 0) ? k * (period / n) : 0;
   endfunction

endpackage

// File: rtl/pwm_dt_channel.sv
// One complementary gate pair: deadtime FSM with dead counter and registered gate decodes.
module pwm_dt_channel
   import pwm_pkg::*;
#(
   parameter int unsigned DTW = 6
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           en_i,
   input  logic           raw_i,
   input  logic [DTW-1:0] dt_sh_i,
   output logic           t1_o,
   output logic           t2_o
);

   ch_state_e      state_q;
   logic [DTW-1:0] dc_q;
   logic           t1_q;
   logic           t2_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StOff;
         dc_q    <= '0;
         t1_q    <= 1'b0;
         t2_q    <= 1'b0;
      end else begin
         // Gates follow the state one cycle late, but drop at once when disabled.
         t1_q <= en_i && (state_q == StHi);
         t2_q <= en_i && (state_q == StLo);
         if (!en_i) begin
            state_q <= StOff;
         end else begin
            unique case (state_q)
               StOff: begin
                  state_q <= raw_i ? StDhi : StDlo;
                  dc_q    <= dt_sh_i;
               end
               StLo: begin
                  if (raw_i) begin
                     state_q <= (dt_sh_i == '0) ? StHi : StDhi;
                     dc_q    <= dt_sh_i;
                  end
               end
               StHi: begin
                  if (!raw_i) begin
                     state_q <= (dt_sh_i == '0) ? StLo : StDlo;
                     dc_q    <= dt_sh_i;
                  end
               end
               StDhi: begin
                  if (!raw_i) begin
                     state_q <= StDlo;
                     dc_q    <= dt_sh_i;
                  end else if (dc_q <= DTW'(1)) begin
                     state_q <= StHi;
                  end else begin
                     dc_q <= dc_q - DTW'(1);
                  end
               end
               StDlo: begin
                  if (raw_i) begin
                     state_q <= StDhi;
                     dc_q    <= dt_sh_i;
                  end else if (dc_q <= DTW'(1)) begin
                     state_q <= StLo;
                  end else begin
                     dc_q <= dc_q - DTW'(1);
                  end
               end
               default: state_q <= StOff;
            endcase
         end
      end
   end

   assign t1_o = t1_q;
   assign t2_o = t2_q;

   no_shoot_through: assert property (@(posedge clk_i) disable iff (rst_i) !(t1_q && t2_q));

endmodule

// File: rtl/pwm_deadtime_nch.sv
// N-channel complementary PWM: shared carrier, shadowed duty/deadtime, interleaved phases.
module pwm_deadtime_nch
   import pwm_pkg::*;
#(
   parameter int unsigned N          = 2,
   parameter int unsigned W          = 10,
   parameter int unsigned PERIOD     = 1000,
   parameter int unsigned DTW        = 6,
   parameter int unsigned INTERLEAVE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N*W-1:0]   d,
   input  logic [DTW-1:0]   dt,
   output logic [N-1:0]     T1,
   output logic [N-1:0]     T2,
   output logic             sync
);

   localparam logic [W-1:0] CntMax  = W'(PERIOD - 1);
   localparam logic [W:0]   PeriodW = (W + 1)'(PERIOD);

   logic [W-1:0]   cnt_q, cnt_d;
   logic [N*W-1:0] d_sh_q;
   logic [DTW-1:0] dt_sh_q;
   logic           live_q;
   logic           load;
   logic [N-1:0]   raw;

   always_comb begin
      cnt_d = '0;
      if (en && (cnt_q != CntMax)) cnt_d = cnt_q + W'(1);
   end

   // Shadows track the inputs while idle so the first enabled period uses fresh values.
   assign load = !en || (cnt_q == CntMax);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         d_sh_q  <= '0;
         dt_sh_q <= '0;
         live_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         live_q <= 1'b1;
         if (load) begin
            d_sh_q  <= d;
            dt_sh_q <= dt;
         end
      end
   end

   // live_q keeps sync low while reset is asserted, even with en high.
   assign sync = en && live_q && (cnt_q == '0);

   for (genvar k = 0; k < N; k++) begin : g_ch
      localparam logic [W:0] Off =
         (W + 1)'(phase_offset(unsigned'(k), N, PERIOD, INTERLEAVE));

      logic [W:0]   sum;
      logic [W-1:0] ph;

      assign sum    = {1'b0, cnt_q} + Off;
      assign ph     = (sum >= PeriodW) ? W'(sum - PeriodW) : sum[W-1:0];
      assign raw[k] = (ph < d_sh_q[k*W +: W]);

      pwm_dt_channel #(
         .DTW (DTW)
      ) u_ch (
         .clk_i   (clk),
         .rst_i   (rst),
         .en_i    (en),
         .raw_i   (raw[k]),
         .dt_sh_i (dt_sh_q),
         .t1_o    (T1[k]),
         .t2_o    (T2[k])
      );
   end

endmodule

// File: tb/tb_pwm_deadtime_nch.sv
// Directed bench for pwm_deadtime_nch: per-period gate counts, extremes, enable and reset cases.
module tb_pwm_deadtime_nch;

   localparam int unsigned N      = 2;
   localparam int unsigned W      = 10;
   localparam int unsigned PERIOD = 1000;
   localparam int unsigned DTW    = 6;

   logic           clk = 1'b0;
   logic           rst;
   logic           en;
   logic [N*W-1:0] d;
   logic [DTW-1:0] dt;
   logic [N-1:0]   t1;
   logic [N-1:0]   t2;
   logic           sync;

   int n_chk = 0;
   int n_bad = 0;

   int mon_dt = 10;
   int ov_cnt = 0;
   int gap_bad = 0;

   int h1[N];
   int h2[N];
   int rise1[N];
   int bl0;
   int nsync;

   always #5 clk = ~clk;

   pwm_deadtime_nch #(
      .N          (N),
      .W          (W),
      .PERIOD     (PERIOD),
      .DTW        (DTW),
      .INTERLEAVE (1)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .d    (d),
      .dt   (dt),
      .T1   (t1),
      .T2   (t2),
      .sync (sync)
   );

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   // Shoot-through and minimum both-low interval before every gate rise.
   initial begin
      int lowrun[N];
      logic [N-1:0] p1, p2;
      for (int k = 0; k < N; k++) lowrun[k] = 100000;
      p1 = '0;
      p2 = '0;
      forever begin
         @(negedge clk);
         for (int k = 0; k < N; k++) begin
            if (t1[k] && t2[k]) ov_cnt++;
            if (((t1[k] && !p1[k]) || (t2[k] && !p2[k])) && (lowrun[k] < mon_dt)) gap_bad++;
            if (t1[k] || t2[k]) lowrun[k] = 0;
            else lowrun[k]++;
         end
         p1 = t1;
         p2 = t2;
      end
   end

   // One carrier period starting at the sync sample; optional d0 change at index chg_at.
   task automatic measure(input int chg_at, input logic [W-1:0] chg_d0);
      logic [N-1:0] p1;
      int guard;
      guard = 0;
      @(negedge clk);
      while (!sync && guard < 2 * PERIOD) begin
         @(negedge clk);
         guard++;
      end
      check_eq("sync_found", sync, 1);
      for (int k = 0; k < N; k++) begin
         h1[k] = 0;
         h2[k] = 0;
         rise1[k] = -1;
      end
      bl0 = 0;
      nsync = 0;
      p1 = t1;
      for (int i = 0; i < PERIOD; i++) begin
         if (i > 0) @(negedge clk);
         if (i == chg_at) d[W-1:0] = chg_d0;
         for (int k = 0; k < N; k++) begin
            if (t1[k]) h1[k]++;
            if (t2[k]) h2[k]++;
            if (t1[k] && !p1[k] && rise1[k] < 0) rise1[k] = i;
         end
         if (!t1[0] && !t2[0]) bl0++;
         if (sync) nsync++;
         p1 = t1;
      end
   endtask

   // After a fresh start from OFF: ch0 drives high side, ch1 low side, both after the dead time.
   task automatic first_rise(input string tag);
      int r0;
      int r1;
      int stray;
      r0 = -1;
      r1 = -1;
      stray = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (t1[0] && r0 < 0) r0 = i;
         if (t2[1] && r1 < 0) r1 = i;
         if (t2[0] || t1[1]) stray++;
      end
      check_eq({tag, "_t1_0_rise"}, r0, 12);
      check_eq({tag, "_t2_1_rise"}, r1, 12);
      check_eq({tag, "_stray"}, stray, 0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      d   = {10'd500, 10'd500};
      dt  = 6'd10;
      #2;
      check_eq("rst_t1", t1, 0);
      check_eq("rst_t2", t2, 0);
      check_eq("rst_sync", sync, 0);
      ticks(3);
      rst = 1'b0;
      ticks(3);
      check_eq("idle_t1", t1, 0);
      check_eq("idle_t2", t2, 0);
      check_eq("idle_sync", sync, 0);
      en = 1'b1;
      first_rise("start");

      measure(-1, '0);
      check_eq("d500_t1_0", h1[0], 490);
      check_eq("d500_t2_0", h2[0], 490);
      check_eq("d500_t1_1", h1[1], 490);
      check_eq("d500_t2_1", h2[1], 490);
      check_eq("d500_deadlow_0", bl0, 20);
      check_eq("d500_rise_0", rise1[0], 12);
      check_eq("d500_rise_1", rise1[1], 512);
      check_eq("d500_nsync", nsync, 1);

      d[W-1:0] = 10'd100;
      measure(-1, '0);
      measure(300, 10'd900);
      check_eq("midchange_keep_t1", h1[0], 90);
      measure(-1, '0);
      check_eq("d900_t1", h1[0], 890);
      check_eq("d900_t2", h2[0], 90);

      d[W-1:0] = 10'd0;
      measure(-1, '0);
      measure(-1, '0);
      check_eq("d0_t1", h1[0], 0);
      check_eq("d0_t2", h2[0], 1000);

      d[W-1:0] = 10'd999;
      measure(-1, '0);
      measure(-1, '0);
      check_eq("d999_t1", h1[0], 989);
      check_eq("d999_t2", h2[0], 0);

      d[W-1:0] = 10'd1000;
      measure(-1, '0);
      measure(-1, '0);
      check_eq("d1000_t1", h1[0], 1000);
      check_eq("d1000_t2", h2[0], 0);

      d[W-1:0] = 10'd5;
      measure(-1, '0);
      measure(-1, '0);
      check_eq("d5_t1", h1[0], 0);
      check_eq("d5_t2", h2[0], 985);

      mon_dt = 0;
      dt = 6'd0;
      d[W-1:0] = 10'd500;
      measure(-1, '0);
      measure(-1, '0);
      check_eq("dt0_t1", h1[0], 500);
      check_eq("dt0_t2", h2[0], 500);
      check_eq("dt0_nogap", bl0, 0);

      dt = 6'd10;
      measure(-1, '0);
      mon_dt = 10;
      measure(-1, '0);
      check_eq("dt10_back_t1", h1[0], 490);

      ticks(100);
      check_eq("pre_off_t1_0", t1[0], 1);
      en = 1'b0;
      @(negedge clk);
      check_eq("off_t1", t1, 0);
      check_eq("off_t2", t2, 0);
      check_eq("off_sync", sync, 0);
      ticks(5);
      check_eq("off_hold_t2", t2, 0);
      en = 1'b1;
      first_rise("reen");

      ticks(300);
      #2;
      rst = 1'b1;
      en = 1'b0;
      #1;
      check_eq("arst_t1", t1, 0);
      check_eq("arst_t2", t2, 0);
      check_eq("arst_sync", sync, 0);
      ticks(3);
      rst = 1'b0;
      ticks(3);
      check_eq("post_rst_t1", t1, 0);
      en = 1'b1;
      first_rise("rerst");

      ticks(20);
      check_eq("no_overlap", ov_cnt, 0);
      check_eq("dead_gap", gap_bad, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
